// File: rtl/seqdet_pkg.sv
// Shared state encoding and default sizing for the serial pattern detector.
package seqdet_pkg;

  localparam int unsigned N_DEF     = 2;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill   = 2'd1,
    StDetect = 2'd2
  } state_e;

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating match counter; a synchronous clear takes priority over an increment.
module seqdet_sat_counter
  import seqdet_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with registered match pulse and saturating counter.
// Define SEQDET_MASK_EN to add the care_mask don't-care input.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w_valid,
  input  logic             w,
  input  logic [N-1:0]     pattern,
`ifdef SEQDET_MASK_EN
  input  logic [N-1:0]     care_mask,
`endif
  input  logic             overlap,
  input  logic             clr_count,
  output logic             z,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam logic [FW-1:0] FillMax = FW'(N);

  state_e         state_q, state_d;
  logic [N-1:0]   window_q, window_d;
  logic [FW-1:0]  fill_q, fill_d, fill_inc;
  logic [N-1:0]   cmp_mask;
  logic           z_q;
  logic           match;

`ifdef SEQDET_MASK_EN
  assign cmp_mask = care_mask;
`else
  assign cmp_mask = '1;
`endif

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    fill_inc = (fill_q == FillMax) ? FillMax : fill_q + 1'b1;
    match    = 1'b0;
    if (!en) begin
      state_d  = StIdle;
      window_d = '0;
      fill_d   = '0;
    end else begin
      if (w_valid) begin
        window_d = {window_q[N-2:0], w};
        fill_d   = fill_inc;
        match    = (fill_inc == FillMax) && (((window_d ^ pattern) & cmp_mask) == '0);
        // Non-overlap mode needs N fresh bits before the next match.
        if (match && !overlap) begin
          fill_d = '0;
        end
      end
      state_d = (fill_d == FillMax) ? StDetect : StFill;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      window_q <= '0;
      fill_q   <= '0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      z_q      <= match;
    end
  end

  assign z     = z_q;
  assign armed = (state_q == StDetect);

  seqdet_sat_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (clr_count),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed check of two detector instances (N=4/CNT_W=2 and N=2/CNT_W=8)
// against a bit-log reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, w_valid = 1'b0, w = 1'b0, overlap = 1'b1, clr_count = 1'b0;
  logic [3:0] pat4 = 4'b1011;
  logic [1:0] pat2 = 2'b11;
  logic       z4, armed4, z2, armed2;
  logic [1:0] mc4;
  logic [7:0] mc2;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: append-only log of accepted bits since the last restart.
  bit log4[64];
  bit log2[64];
  int cnt4 = 0, cnt2 = 0;
  int ecnt4 = 0, ecnt2 = 0;
  bit ez4 = 0, ez2 = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.N(4), .CNT_W(2)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .w_valid    (w_valid),
    .w          (w),
    .pattern    (pat4),
`ifdef SEQDET_MASK_EN
    .care_mask  (4'hf),
`endif
    .overlap    (overlap),
    .clr_count  (clr_count),
    .z          (z4),
    .armed      (armed4),
    .match_count(mc4)
  );

  seq_detector_param #(.N(2), .CNT_W(8)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .w_valid    (w_valid),
    .w          (w),
    .pattern    (pat2),
`ifdef SEQDET_MASK_EN
    .care_mask  (2'h3),
`endif
    .overlap    (overlap),
    .clr_count  (clr_count),
    .z          (z2),
    .armed      (armed2),
    .match_count(mc2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Last n logged bits equal the pattern (pattern[0] = newest bit).
  function automatic bit tail_match(input int n, input logic [3:0] pat, input bit lg[64],
                                    input int c);
    if (c < n) return 1'b0;
    for (int k = 0; k < n; k++) begin
      if (lg[(c - 1 - k) % 64] != pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit m4, m2;
    m4 = 0;
    m2 = 0;
    if (!en) begin
      cnt4 = 0;
      cnt2 = 0;
    end else if (w_valid) begin
      log4[cnt4 % 64] = w;
      cnt4++;
      log2[cnt2 % 64] = w;
      cnt2++;
      m4 = tail_match(4, pat4, log4, cnt4);
      m2 = tail_match(2, {2'b00, pat2}, log2, cnt2);
      if (m4 && !overlap) cnt4 = 0;
      if (m2 && !overlap) cnt2 = 0;
    end
    ez4 = m4;
    ez2 = m2;
    if (clr_count) begin
      ecnt4 = 0;
      ecnt2 = 0;
    end else begin
      if (m4 && ecnt4 < 3) ecnt4++;
      if (m2 && ecnt2 < 255) ecnt2++;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".z4"}, 32'(z4), 32'(ez4));
    check_eq({tag, ".armed4"}, 32'(armed4), 32'(en && cnt4 >= 4));
    check_eq({tag, ".cnt4"}, 32'(mc4), 32'(ecnt4));
    check_eq({tag, ".z2"}, 32'(z2), 32'(ez2));
    check_eq({tag, ".armed2"}, 32'(armed2), 32'(en && cnt2 >= 2));
    check_eq({tag, ".cnt2"}, 32'(mc2), 32'(ecnt2));
  endtask

  task automatic step(input string tag, input bit e, input bit v, input bit b, input bit clr);
    en        = e;
    w_valid   = v;
    w         = b;
    clr_count = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_bits(input string tag, input bit bits[$]);
    foreach (bits[i]) step(tag, 1'b1, 1'b1, bits[i], 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    cnt4  = 0;
    cnt2  = 0;
    ecnt4 = 0;
    ecnt2 = 0;
    ez4   = 0;
    ez2   = 0;
    check_eq({tag, ".rst_z4"}, 32'(z4), 0);
    check_eq({tag, ".rst_armed4"}, 32'(armed4), 0);
    check_eq({tag, ".rst_cnt4"}, 32'(mc4), 0);
    check_eq({tag, ".rst_cnt2"}, 32'(mc2), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit s1[$] = '{1, 0, 1, 1, 0, 1, 1};
    bit s3[$] = '{0, 1, 1, 1, 0};
    bit gap[$] = '{1, 0, 1, 1};
    bit tail[$] = '{0, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // Overlapping matches after bits 4 and 7.
    overlap = 1'b1;
    pat4 = 4'b1011;
    send_bits("t1", s1);
    check_eq("t1.total4", 32'(mc4), 2);
    step("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    do_reset("t2");
    overlap = 1'b0;
    send_bits("t2", s1);
    check_eq("t2.total4", 32'(mc4), 1);
    check_eq("t2.armed_end", 32'(armed4), 0);
    step("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Legacy two-ones behaviour on the N=2 instance.
    do_reset("t3");
    overlap = 1'b1;
    pat2 = 2'b11;
    send_bits("t3", s3);
    check_eq("t3.total2", 32'(mc2), 2);
    step("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Gaps in w_valid hold the window and keep z low.
    do_reset("t4");
    foreach (gap[i]) begin
      step("t4.bit", 1'b1, 1'b1, gap[i], 1'b0);
      step("t4.gap", 1'b1, 1'b0, ~gap[i], 1'b0);
    end
    check_eq("t4.total4", 32'(mc4), 1);
    step("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation at 3, then clear wins against a simultaneous match.
    do_reset("t5");
    send_bits("t5", gap);
    repeat (4) send_bits("t5", tail);
    check_eq("t5.sat4", 32'(mc4), 3);
    step("t5.pre", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t5.pre", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t5.clr", 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("t5.clr_z4", 32'(z4), 1);
    check_eq("t5.clr_cnt4", 32'(mc4), 0);
    step("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-pattern discards the partial window.
    do_reset("t6a");
    send_bits("t6", '{1, 0, 1});
    do_reset("t6b");
    step("t6.last", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("t6.no_z4", 32'(z4), 0);

    // Randomised traffic with live pattern/overlap changes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) pat4 = 4'($urandom);
      if ($urandom_range(0, 49) == 0) pat2 = 2'($urandom);
      if ($urandom_range(0, 29) == 0) overlap = 1'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset("rnd");
      step("rnd", $urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial-bit pattern detector with registered Mealy-style output.
- Successor to the fixed two-state "two consecutive 1s" detector; the default configuration (N=2, pattern 2'b11, overlap=1) reproduces that behaviour.
- Adds the following over it:
  - programmable N-bit pattern;
  - input qualifier;
  - overlap/non-overlap mode;
  - enable;
  - saturating match counter.
- Sits between a serial input source and status/control logic in lab-level designs.

Parameters:
- N, 2: pattern length in bits, N >= 2.
- CNT_W, 8: width of match counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  detector enable; low forces IDLE
- w_valid  input  1  qualifies w; bit accepted on a rising clk edge when en=1 and w_valid=1
- w  input  1  serial data bit
- pattern  input  N  target sequence; pattern[N-1] = oldest bit, pattern[0] = newest
- overlap  input  1  1 = overlapping matches allowed; 0 = window restarts after a match
- clr_count  input  1  synchronous clear of match_count
- z  output  1  one-cycle match pulse, registered
- armed  output  1  window holds >= N valid bits
- match_count  output  CNT_W  saturating count of matches

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, window=0, fill=0;
  - z=0, armed=0, match_count=0.
- States:
  - IDLE: en=0; window and fill cleared each cycle; z=0; match_count held.
  - FILL: fill < N.
  - DETECT: fill == N.
  - Transitions:
    - IDLE -> FILL when en=1.
    - FILL -> DETECT when an accepted bit makes fill reach N.
    - DETECT -> FILL on a match with overlap=0.
    - Any state -> IDLE when en=0; takes effect at the next edge and overrides all else.
- Accepted bit (en=1, w_valid=1):
  - window_next = {window[N-2:0], w};
  - fill_next = min(fill+1, N).
- Match condition: accepted bit AND fill_next == N AND window_next == pattern.
- Outputs on a match:
  - z=1 on the next edge, for exactly one cycle. Latency: 1 clk from the accepting edge.
  - match_count increments on the same edge.
- z=0 in every cycle without a match, including w_valid=0 cycles. The window and fill are held while w_valid=0.
- Match handling by mode:
  - overlap=1: fill stays at N; the next bit may complete a new match.
  - overlap=0: fill cleared to 0 on the match edge. The next match needs N fresh accepted bits.
- armed = (state == DETECT), registered.
- pattern and overlap are sampled live at each accepted bit. A change takes effect on the next accepted bit; the window is not flushed.
- match_count:
  - saturates at 2^CNT_W-1; further matches still pulse z;
  - clr_count=1 clears it to 0;
  - clr_count and a match on the same edge: clear wins, result 0.
- Reset asserted mid-sequence: immediate return to reset values. The partial window is discarded.

Optional Feature:
- Macro: SEQDET_MASK_EN
- Defined:
  - adds input port care_mask [N-1:0]; bit=1 means compare, bit=0 means don't-care.
  - Match condition becomes ((window_next ^ pattern) & care_mask) == 0.
  - care_mask all-zero matches on every accepted bit once fill == N.
- Undefined: port absent; all bits compared exactly.

Decomposition:
- Package seqdet_pkg: state encoding (IDLE=2'd0, FILL=2'd1, DETECT=2'd2) and default constants N_DEF=2, CNT_W_DEF=8.
- Sub-module seqdet_sat_counter (param CNT_W):
  - inputs: inc, clr, clk, reset;
  - output: count;
  - clr priority and saturation live here.

Test Plan:
- N=4, pattern=4'b1011, overlap=1, stream 1,0,1,1,0,1,1 (w_valid=1 every cycle) -> z pulses after bits 4 and 7; match_count=2.
- Same stream, overlap=0 -> z pulses only after bit 4; match_count=1; armed low from the cycle after bit 4 until the stream ends.
- N=2, pattern=2'b11, overlap=1, stream 0,1,1,1,0 -> z high after bits 3 and 4; matches the legacy two-1s detector.
- N=4, w_valid toggled 0 between each bit of 1,0,1,1 -> single z pulse one cycle after the 4th accepted bit; z=0 in all gap cycles.
- CNT_W=2, 5 matches with overlap=1 -> match_count sticks at 3. Then clr_count asserted on the same edge as a match -> match_count=0 and z=1.
- reset pulsed low after 3 of 4 pattern bits, then the 4th bit is sent -> no z; fill restarts from 0.
